// File: rtl/bcd_scan_pkg.sv
// Shared constants and digit extraction helper for the BCD digit scanner.
package bcd_scan_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned BCD_MAX    = 9;
  // Widest packed word the helper accepts; callers zero-extend narrower words.
  localparam int unsigned MAX_DIGITS = 16;
  localparam int unsigned WORD_W     = DIGIT_W * MAX_DIGITS;
  localparam int unsigned WORD_AW    = $clog2(WORD_W);

  // Return digit k (4-bit slice) of a packed BCD word.
  function automatic logic [DIGIT_W-1:0] digit_of(input logic [WORD_W-1:0] word,
                                                  input int unsigned       k);
    logic [WORD_AW-1:0] lsb;
    lsb = WORD_AW'(k * DIGIT_W);
    return word[lsb +: DIGIT_W];
  endfunction

endpackage

// File: rtl/bcd_digit_scanner_prescaler.sv
// Slot prescaler: counts 0..SCAN_DIV-1 and flags the terminal count.
module scan_prescaler #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [$clog2(SCAN_DIV)-1:0] cnt,
  output logic                        tc_c
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  // Terminal count marks the last cycle of a digit slot.
  always_comb begin
    tc_c = (cnt == CNT_W'(SCAN_DIV - 1));
  end

  // Free-running slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tc_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_digit_scanner.sv
// Multiplexed seven-segment digit scanner feeding a shared BCD decoder.
module bcd_digit_scanner
  import bcd_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
  input  logic                          lamp_test,
  input  logic                          blank,
  input  logic                          rbz_en,
  output logic                          D,
  output logic                          C,
  output logic                          B,
  output logic                          A,
  output logic                          LT,
  output logic                          BI,
  output logic                          RBI,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          frame_start,
  output logic                          pending,
  output logic                          err
);

  localparam int unsigned WORD_BITS = DIGIT_W * NUM_DIGITS;
  localparam int unsigned IDX_W     = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W     = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]     cnt;
  logic                 tc_c;
  logic [IDX_W-1:0]     idx_q;
  logic [WORD_BITS-1:0] shadow_q;
  logic [WORD_BITS-1:0] active_q;

  logic [DIGIT_W-1:0]   cur_digit;
  logic                 digit_bad;
  logic                 above_zero;
  logic                 swap;
  logic                 guard;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .tc_c  (tc_c)
  );

  // Current digit decode, suppression qualifier and frame-swap condition.
  always_comb begin
    cur_digit  = digit_of(WORD_W'(active_q), 32'(idx_q));
    digit_bad  = (32'(cur_digit) > BCD_MAX);
    swap       = tc_c && (idx_q == '0);
    guard      = (cnt == '0);
    above_zero = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if ((k > 32'(idx_q)) && (digit_of(WORD_W'(active_q), k) != '0)) begin
        above_zero = 1'b0;
      end
    end
  end

  // Digit index walks MSD to LSD, advancing at each slot boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= IDX_TOP;
    end else if (tc_c) begin
      idx_q <= (idx_q == '0) ? IDX_TOP : idx_q - 1'b1;
    end
  end

  // Double buffer: load fills shadow, frame swap promotes shadow to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pending  <= 1'b0;
    end else begin
      if (load) begin
        shadow_q <= bcd_in;
      end
      if (swap) begin
        active_q <= shadow_q;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (swap) begin
        pending <= 1'b0;
      end
    end
  end

  // Sticky invalid-digit flag; a bad digit this cycle wins over a clearing load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (digit_bad) begin
      err <= 1'b1;
    end else if (load) begin
      err <= 1'b0;
    end
  end

  // Registered decoder drive and digit enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {D, C, B, A} <= '0;
      LT           <= 1'b1;
      BI           <= 1'b0;
      RBI          <= 1'b1;
      digit_sel    <= '0;
      frame_start  <= 1'b0;
    end else begin
      {D, C, B, A} <= cur_digit;
      LT           <= ~lamp_test;
      BI           <= ~(blank | guard | digit_bad);
      RBI          <= ~(rbz_en & (idx_q != '0) & above_zero);
      digit_sel    <= NUM_DIGITS'(1) << idx_q;
      frame_start  <= guard && (idx_q == IDX_TOP);
    end
  end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Randomized and directed bench for bcd_digit_scanner against a frame-level model.
module tb_bcd_digit_scanner;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int FR = N * SD;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd_in;
  logic        lamp_test;
  logic        blank;
  logic        rbz_en;
  logic        D, C, B, A;
  logic        LT, BI, RBI;
  logic [3:0]  digit_sel;
  logic        frame_start;
  logic        pending;
  logic        err;

  int total;
  int bad;

  // Reference model: n counts clock edges since reset release.
  int          n;
  logic [15:0] shadow_m;
  logic [15:0] active_m;
  logic        pending_m;
  logic        err_m;

  bcd_digit_scanner #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (SD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .bcd_in      (bcd_in),
    .lamp_test   (lamp_test),
    .blank       (blank),
    .rbz_en      (rbz_en),
    .D           (D),
    .C           (C),
    .B           (B),
    .A           (A),
    .LT          (LT),
    .BI          (BI),
    .RBI         (RBI),
    .digit_sel   (digit_sel),
    .frame_start (frame_start),
    .pending     (pending),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d, t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  task automatic model_reset();
    n         = 0;
    shadow_m  = '0;
    active_m  = '0;
    pending_m = 1'b0;
    err_m     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dcba"}, 32'({D, C, B, A}), 32'd0);
    check({tag, "_lt"},   32'(LT),           32'd1);
    check({tag, "_bi"},   32'(BI),           32'd0);
    check({tag, "_rbi"},  32'(RBI),          32'd1);
    check({tag, "_sel"},  32'(digit_sel),    32'd0);
    check({tag, "_fs"},   32'(frame_start),  32'd0);
    check({tag, "_pend"}, 32'(pending),      32'd0);
    check({tag, "_err"},  32'(err),          32'd0);
  endtask

  // One clock: predict outputs from the pre-edge slot position, then compare.
  task automatic cycle();
    int          c;
    int          i;
    logic [3:0]  d;
    logic [31:0] upper;
    logic        e_bi;
    logic        e_rbi;
    logic        e_fs;
    logic        sw;
    c     = n % SD;
    i     = N - 1 - ((n / SD) % N);
    d     = active_m[4*i +: 4];
    upper = 32'(active_m) >> (4 * (i + 1));
    e_bi  = !(blank || (c == 0) || (d > 4'd9));
    e_rbi = !(rbz_en && (i != 0) && (upper == 0));
    e_fs  = (c == 0) && (i == N - 1);
    sw    = (c == SD - 1) && (i == 0);
    @(posedge clk);
    if (d > 4'd9)  err_m = 1'b1;
    else if (load) err_m = 1'b0;
    if (load)      pending_m = 1'b1;
    else if (sw)   pending_m = 1'b0;
    if (sw)   active_m = shadow_m;
    if (load) shadow_m = bcd_in;
    n++;
    #1;
    check("dcba", 32'({D, C, B, A}), 32'(d));
    check("sel",  32'(digit_sel),    32'(1 << i));
    check("lt",   32'(LT),           32'(!lamp_test));
    check("bi",   32'(BI),           32'(e_bi));
    check("rbi",  32'(RBI),          32'(e_rbi));
    check("fs",   32'(frame_start),  32'(e_fs));
    check("pend", 32'(pending),      32'(pending_m));
    check("err",  32'(err),          32'(err_m));
  endtask

  task automatic run(input int k);
    for (int j = 0; j < k; j++) cycle();
  endtask

  task automatic load_word(input logic [15:0] w);
    bcd_in = w;
    load   = 1'b1;
    cycle();
    load   = 1'b0;
  endtask

  // Advance until the model's slot position within the frame equals pos.
  task automatic run_to(input int pos);
    for (int j = 0; j < FR && (n % FR) != pos; j++) cycle();
  endtask

  initial begin
    logic [15:0] w;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    load      = 1'b0;
    bcd_in    = '0;
    lamp_test = 1'b0;
    blank     = 1'b0;
    rbz_en    = 1'b0;
    model_reset();

    #12;
    check_reset_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("post_release");

    // Plain display of 1234.
    load_word(16'h1234);
    run(3 * FR);

    // Leading-zero suppression on 0050.
    rbz_en = 1'b1;
    load_word(16'h0050);
    run(3 * FR);
    rbz_en = 1'b0;

    // Invalid digit sets err; a later valid load, swapped in, clears it.
    load_word(16'h12A4);
    run(2 * FR);
    run_to(12);
    load_word(16'h1234);
    run(2 * FR);

    // Load coincident with the swap edge stays in shadow for one more frame.
    load_word(16'h1111);
    run_to(FR - 1);
    load_word(16'h9999);
    run(2 * FR);

    // Lamp test, then blanking, while scanning continues.
    run(5);
    lamp_test = 1'b1;
    run(6);
    blank = 1'b1;
    run(FR);
    lamp_test = 1'b0;
    blank     = 1'b0;
    run(4);

    // Asynchronous reset mid-slot (idx=2, cnt=2).
    run_to(6);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("rst_release2");
    run(2 * FR);

    // Randomized traffic.
    for (int j = 0; j < 800; j++) begin
      load = ($urandom_range(0, 11) == 0);
      if (load) begin
        for (int k = 0; k < N; k++) begin
          w[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
        end
        bcd_in = w;
      end else begin
        bcd_in = 16'($urandom());
      end
      if ($urandom_range(0, 40) == 0) lamp_test = ~lamp_test;
      if ($urandom_range(0, 40) == 0) blank     = ~blank;
      if ($urandom_range(0, 30) == 0) rbz_en    = ~rbz_en;
      cycle();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
